// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor
// cell evaluated per clock. The result is packed as {borrow_out, difference}.
//
// Optional build macro SERIAL_SUBTRACTOR_ADD_EN adds an 'op' input
// (0 = subtract, 1 = add, with bin acting as carry-in).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// SHIFT | one bit per edge through the cell, WIDTH edges in total
// DONE  | diff valid and held until out_ready, in_ready=0

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // sh_a holds the minuend and doubles as the result register: each SHIFT
    // edge consumes one minuend bit at the bottom and fills the freed top
    // slot with the new difference bit.
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   diff_q;
    logic             add_q;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_nxt;
    logic             last_bit;

    assign ai       = sh_a[0];
    assign bi       = sh_b[0];
    assign d        = ai ^ bi ^ br;
    assign last_bit = (cnt == LAST);

    // Full-subtractor borrow, or full-adder carry when the add option is latched.
    always_comb begin
        br_nxt = (~ai & bi) | (~ai & br) | (bi & br);
        if (add_q) begin
            br_nxt = (ai & bi) | (ai & br) | (bi & br);
        end
    end

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    // Operation select is captured together with the operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            add_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            add_q <= op;
        end
    end
`else
    assign add_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and final result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_a <= a;
                        sh_b <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sh_a <= {d, sh_a[WIDTH-1:1]};
                    sh_b <= {1'b0, sh_b[WIDTH-1:1]};
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        diff_q <= {br_nxt, d, sh_a[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign diff      = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors, an exhaustive operand sweep with
// random out_ready, backpressure and mid-operation reset, checked against
// an arithmetic/timing model plus hand-computed literal results.

module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << (WIDTH + 1)) - 1;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int or_mode = 1;

    // reference model state: what the block must look like after the next edge
    bit m_idle = 1'b1;
    int m_left = 0;
    bit m_done = 1'b0;
    int m_res  = 0;
    int n_acc  = 0;
    int n_res  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(input int x, input int y, input int c, input int o);
        if (o != 0) return (x + y + c) & MASK;
        return (x - y - c) & MASK;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // out_ready driver: 0 = held low, 1 = held high, 2 = random per cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            m_idle = 1'b1;
            m_left = 0;
            m_done = 1'b0;
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_diff", int'(diff), 0);
        end else begin
            chk("cyc_in_ready", int'(in_ready), int'(m_idle));
            chk("cyc_busy", int'(busy), int'(!m_idle));
            chk("cyc_out_valid", int'(out_valid), int'(m_done));
            if (m_done) chk("cyc_diff", int'(diff), m_res);
            if (m_idle) begin
                if (in_valid) begin
                    m_idle = 1'b0;
                    m_left = WIDTH;
                    m_res  = model(int'(a), int'(b), int'(bin), int'(op));
                    n_acc++;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (out_ready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
                n_res++;
            end
        end
    end

    // present operands and return one step after the accepting edge
    task automatic submit(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic tbin, input bit hold_valid);
        int n;
        a        = ta;
        b        = tbv;
        bin      = tbin;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
        a   = WIDTH'($urandom_range(15));
        b   = WIDTH'($urandom_range(15));
        bin = 1'($urandom_range(1));
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic tbin, input int exp, input string nm,
                          input bit hold_valid);
        int k;
        submit(ta, tbv, tbin, hold_valid);
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({"lat_", nm}, k, WIDTH);
        chk({"diff_", nm}, int'(diff), exp);
    endtask

    task automatic finish_release(input string nm);
        chk({"done_in_ready_", nm}, int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk({"idle_in_ready_", nm}, int'(in_ready), 1);
        chk({"idle_out_valid_", nm}, int'(out_valid), 0);
        chk({"idle_busy_", nm}, int'(busy), 0);
    endtask

    initial begin
        int r0;
        int n;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        op       = 1'b0;
        #3;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_diff", int'(diff), 0);
        #19;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // directed vectors, out_ready held high
        run_op(4'd5, 4'd3, 1'b0, 5'b00010, "5m3", 1'b0);
        finish_release("5m3");
        run_op(4'd3, 4'd5, 1'b0, 5'b11110, "3m5", 1'b0);
        finish_release("3m5");
        run_op(4'd0, 4'd0, 1'b1, 5'b11111, "0m0b", 1'b0);
        finish_release("0m0b");
        run_op(4'd15, 4'd0, 1'b0, 5'b01111, "15m0", 1'b0);
        finish_release("15m0");

        // exhaustive sweep with random out_ready
        or_mode = 2;
        r0 = n_res;
        for (int i = 0; i < 512; i++) begin
            submit(WIDTH'(i & 15), WIDTH'((i >> 4) & 15), 1'((i >> 8) & 1), 1'b0);
        end
        or_mode = 1;
        n = 0;
        while (!(in_ready && !out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_drain", int'(in_ready), 1);
        chk("sweep_count", n_res - r0, 512);

        // backpressure with in_valid kept high
        or_mode = 0;
        @(posedge clk);
        #1;
        r0 = n_acc;
        run_op(4'd12, 4'd7, 1'b1, 5'b00100, "bp", 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_diff", int'(diff), 5'b00100);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        chk("bp_no_second_accept", n_acc - r0, 1);
        in_valid = 1'b0;
        or_mode  = 1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);

        // reset two SHIFT cycles into an operation
        submit(4'd6, 4'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_diff", int'(diff), 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(4'd9, 4'd4, 1'b0, 5'b00101, "after_rst", 1'b0);
        finish_release("after_rst");

`ifdef SERIAL_SUBTRACTOR_ADD_EN
        op = 1'b1;
        run_op(4'd9, 4'd8, 1'b1, 5'b10010, "add", 1'b0);
        op = 1'b0;
        finish_release("add");
        run_op(4'd9, 4'd8, 1'b1, 5'b00000, "sub", 1'b0);
        finish_release("sub");
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
